// File: rtl/board_reset_controller_if.sv
// Board-side button inputs and core-side reset/halt outputs of the reset controller.
// The master drives the buttons. The slave, which is the controller, drives the core signals.
interface board_reset_controller_if;
  logic       reset_button;
  logic       halt_button;
  logic       core_reset_n;
  logic       core_halt;
  logic [1:0] state;

  modport master (
    output reset_button,
    output halt_button,
    input  core_reset_n,
    input  core_halt,
    input  state
  );

  modport slave (
    input  reset_button,
    input  halt_button,
    output core_reset_n,
    output core_halt,
    output state
  );
endinterface

// File: rtl/board_reset_controller.sv
// Board reset/halt sequencer: synchronizes and debounces the push-buttons, then stretches core reset.
// An optional mode turns the halt button into a press-to-toggle run/halt latch.
module board_reset_controller #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int RESET_HOLD_CYCLES = 1024,
  parameter bit HALT_TOGGLE       = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  board_reset_controller_if.slave  bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PRESSED = 2'd2
  } state_t;

  // Index 0 is the reset button and index 1 is the halt button.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [DW-1:0] deb_cnt [2];

  state_t        st;
  logic [HW-1:0] hold_cnt;
  logic          deb_halt_q;
  logic          halt_latch;
  logic          core_reset_n_r;
  logic          halt_rise;

  assign raw       = {bus.halt_button, bus.reset_button};
  assign halt_rise = deb[1] & ~deb_halt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      deb        <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // state      | meaning
  // ST_HOLD    | core held in reset while the hold timer counts up
  // ST_RUN     | core released; halt latch active
  // ST_PRESSED | reset button held; waiting for a debounced release
  always_ff @(posedge clock) begin
    if (reset) begin
      st             <= ST_HOLD;
      hold_cnt       <= '0;
      deb_halt_q     <= 1'b0;
      halt_latch     <= 1'b0;
      core_reset_n_r <= 1'b0;
    end else begin
      deb_halt_q <= deb[1];
      case (st)
        ST_HOLD: begin
          halt_latch <= 1'b0;
          if (deb[0]) begin
            st       <= ST_PRESSED;
            hold_cnt <= '0;
          end else if (hold_cnt == HW'(RESET_HOLD_CYCLES - 1)) begin
            st             <= ST_RUN;
            core_reset_n_r <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        ST_RUN: begin
          // A reset press takes priority over any halt activity on the same edge.
          if (deb[0]) begin
            st             <= ST_PRESSED;
            core_reset_n_r <= 1'b0;
            halt_latch     <= 1'b0;
          end else if (HALT_TOGGLE) begin
            if (halt_rise) halt_latch <= ~halt_latch;
          end else begin
            halt_latch <= deb[1];
          end
        end
        ST_PRESSED: begin
          halt_latch <= 1'b0;
          if (!deb[0]) begin
            st       <= ST_HOLD;
            hold_cnt <= '0;
          end
        end
        default: begin
          st             <= ST_HOLD;
          hold_cnt       <= '0;
          halt_latch     <= 1'b0;
          core_reset_n_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.core_reset_n = core_reset_n_r;
  assign bus.core_halt    = halt_latch;
  assign bus.state        = st;

endmodule
